// File: rtl/ultrasonic_sequencer.sv
// Ultrasonic ranging sequencer: trigger pulse, echo timing with timeout, on-the-fly
// centimetre conversion, valid/ready result hand-off and a minimum trigger period.
module ultrasonic_sequencer #(
    parameter int TRIG_CYCLES    = 120,
    parameter int CYC_PER_CM     = 696,
    parameter int MAX_CM         = 400,
    parameter int TIMEOUT_CYCLES = 300000,
    parameter int PERIOD_CYCLES  = 720000
) (
    input  logic       hw_clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       start,
    input  logic       echo,
    output logic       trig,
    output logic       busy,
    output logic       dist_valid,
    input  logic       dist_ready,
    output logic [8:0] distance_cm,
    output logic       timeout,
    output logic [2:0] dbg_state
);
    // Result handshake: dist_valid rises with distance_cm/timeout loaded and holds them
    // unchanged until a cycle with dist_ready=1; it drops on the following edge.
    // A new launch is blocked while dist_valid is high, so no result is ever overwritten.

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG      = 3'd1,
        WAIT_RISE = 3'd2,
        MEASURE   = 3'd3,
        RESULT    = 3'd4,
        HOLDOFF   = 3'd5
    } state_t;

    localparam int              SUB_W     = $clog2(CYC_PER_CM);
    localparam logic [19:0]     TRIG_LAST = 20'(TRIG_CYCLES - 1);
    localparam logic [19:0]     HIGH_LIM  = 20'(TIMEOUT_CYCLES);
    localparam logic [19:0]     WAIT_LIM  = 20'(TIMEOUT_CYCLES - 1);
    localparam logic [19:0]     PER_LAST  = 20'(PERIOD_CYCLES - 1);
    localparam logic [19:0]     CNT_SAT   = 20'hFFFFF;
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CYC_PER_CM - 1);
    localparam logic [8:0]      CM_MAX    = 9'(MAX_CM);

    state_t            state;
    logic              echo_s1, echo_s2, echo_d;
    logic [19:0]       tcnt;
    logic [19:0]       tcnt_inc;
    logic [19:0]       period_cnt;
    logic [SUB_W-1:0]  sub_cnt;
    logic [8:0]        cm;
    logic              to_flag;

    assign tcnt_inc  = tcnt + 20'd1;
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_ff @(posedge hw_clk) begin
        if (rst) begin
            state       <= IDLE;
            echo_s1     <= 1'b0;
            echo_s2     <= 1'b0;
            echo_d      <= 1'b0;
            tcnt        <= '0;
            period_cnt  <= CNT_SAT;
            sub_cnt     <= '0;
            cm          <= '0;
            to_flag     <= 1'b0;
            trig        <= 1'b0;
            dist_valid  <= 1'b0;
            distance_cm <= '0;
            timeout     <= 1'b0;
        end else begin
            echo_s1 <= echo;
            echo_s2 <= echo_s1;
            echo_d  <= echo_s2;

            if (period_cnt != CNT_SAT)
                period_cnt <= period_cnt + 20'd1;

            if (dist_valid && dist_ready)
                dist_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if ((enable || start) && !dist_valid) begin
                        state      <= TRIG;
                        trig       <= 1'b1;
                        tcnt       <= '0;
                        to_flag    <= 1'b0;
                        // The trig-high cycle counts as the first elapsed period cycle,
                        // which makes rise-to-rise spacing exactly PERIOD_CYCLES.
                        period_cnt <= 20'd1;
                    end
                end
                TRIG: begin
                    if (tcnt == TRIG_LAST) begin
                        trig  <= 1'b0;
                        tcnt  <= '0;
                        state <= WAIT_RISE;
                    end else begin
                        tcnt <= tcnt_inc;
                    end
                end
                WAIT_RISE: begin
                    if (echo_s2 && !echo_d) begin
                        // The rising-edge cycle is itself the first echo-high cycle.
                        state   <= MEASURE;
                        tcnt    <= 20'd1;
                        sub_cnt <= SUB_W'(1);
                        cm      <= '0;
                    end else if (tcnt_inc >= WAIT_LIM) begin
                        state   <= RESULT;
                        cm      <= CM_MAX;
                        to_flag <= 1'b1;
                    end else begin
                        tcnt <= tcnt_inc;
                    end
                end
                MEASURE: begin
                    if (!echo_s2) begin
                        state <= RESULT;
                    end else if (tcnt_inc >= HIGH_LIM) begin
                        state   <= RESULT;
                        cm      <= CM_MAX;
                        to_flag <= 1'b1;
                    end else begin
                        tcnt <= tcnt_inc;
                        if (sub_cnt == SUB_LAST) begin
                            sub_cnt <= '0;
                            if (cm != CM_MAX)
                                cm <= cm + 9'd1;
                        end else begin
                            sub_cnt <= sub_cnt + SUB_W'(1);
                        end
                    end
                end
                RESULT: begin
                    distance_cm <= cm;
                    timeout     <= to_flag;
                    dist_valid  <= 1'b1;
                    state       <= HOLDOFF;
                end
                HOLDOFF: begin
                    if (period_cnt >= PER_LAST)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ultrasonic_sequencer.sv
// Scoreboard bench for ultrasonic_sequencer with scaled-down timing parameters.
module tb_ultrasonic_sequencer;
    localparam int TRIG_C  = 12;
    localparam int CPC     = 20;
    localparam int MAXC    = 40;
    localparam int TO_C    = 1000;
    localparam int PER_C   = 3000;
    localparam int LIMIT   = 8000;

    logic       hw_clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       start = 1'b0;
    logic       echo = 1'b0;
    logic       dist_ready = 1'b1;
    logic       trig, busy, dist_valid, timeout;
    logic [8:0] distance_cm;
    logic [2:0] dbg_state;

    ultrasonic_sequencer #(
        .TRIG_CYCLES(TRIG_C), .CYC_PER_CM(CPC), .MAX_CM(MAXC),
        .TIMEOUT_CYCLES(TO_C), .PERIOD_CYCLES(PER_C)
    ) dut (
        .hw_clk(hw_clk), .rst(rst), .enable(enable), .start(start), .echo(echo),
        .trig(trig), .busy(busy), .dist_valid(dist_valid), .dist_ready(dist_ready),
        .distance_cm(distance_cm), .timeout(timeout), .dbg_state(dbg_state)
    );

    // clock / cycle counter
    always #5 hw_clk = ~hw_clk;
    int cyc = 0;
    always @(posedge hw_clk) cyc++;

    int n_checks = 0;
    int n_pass   = 0;
    logic [9:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    endtask

    // trig monitor: pulse width and rise/fall timestamps
    int   rise_q[$];
    int   last_fall = 0;
    int   trig_w = 0;
    logic trig_prev = 1'b0;
    always @(negedge hw_clk) begin
        if (trig) trig_w++;
        if (trig && !trig_prev) rise_q.push_back(cyc);
        if (!trig && trig_prev) begin
            last_fall = cyc;
            check("trig_width", trig_w, TRIG_C);
            trig_w = 0;
        end
        trig_prev = trig;
    end

    // result monitor: scoreboard pop on accept, stability while held
    logic       held = 1'b0;
    logic [9:0] held_val = '0;
    logic       just_acc = 1'b0;
    logic       valid_prev = 1'b0;
    int         acc_cyc = 0;
    int         vrise = 0;
    always @(negedge hw_clk) begin
        if (just_acc) check("valid_drop", dist_valid, 0);
        just_acc = 1'b0;
        if (dist_valid && !valid_prev) vrise = cyc;
        if (dist_valid) begin
            if (held) check("hold_stable", {timeout, distance_cm}, held_val);
            if (dist_ready) begin
                if (exp_q.size() == 0) check("unexpected_result", {timeout, distance_cm}, 10'h3FF);
                else check("result", {timeout, distance_cm}, exp_q.pop_front());
                held = 1'b0;
                just_acc = 1'b1;
                acc_cyc = cyc;
            end else begin
                held = 1'b1;
                held_val = {timeout, distance_cm};
            end
        end
        valid_prev = dist_valid;
    end

    // driver tasks
    task automatic tick();
        @(posedge hw_clk); #1;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic wait_trig_fall();
        int n = 0;
        while (!trig && n < LIMIT) begin tick(); n++; end
        while (trig && n < LIMIT) begin tick(); n++; end
        check("trig_fall_wait", n < LIMIT, 1);
    endtask

    task automatic measure(input int width, input int gap);
        wait_trig_fall();
        repeat (gap) tick();
        echo = 1'b1;
        repeat (width) tick();
        echo = 1'b0;
    endtask

    task automatic wait_drained();
        int n = 0;
        while (exp_q.size() != 0 && n < LIMIT) begin tick(); n++; end
        check("result_wait", n < LIMIT, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < LIMIT) begin tick(); n++; end
        check("idle_wait", n < LIMIT, 1);
    endtask

    task automatic one_shot(input int width, input int exp_cm, input logic exp_to);
        exp_q.push_back({exp_to, 9'(exp_cm)});
        pulse_start();
        measure(width, 5);
        wait_drained();
        wait_idle();
    endtask

    initial begin
        int n0;
        int a;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_trig", trig, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", dist_valid, 0);
        check("rst_dist", distance_cm, 0);
        check("rst_timeout", timeout, 0);
        check("rst_state", dbg_state, 0);

        // width table: cm = floor(width / CPC), saturating at MAXC; TO_C -> timeout
        one_shot(30 * CPC, 30, 1'b0);
        one_shot(CPC - 1, 0, 1'b0);
        one_shot(CPC, 1, 1'b0);
        one_shot(MAXC * CPC, MAXC, 1'b0);
        one_shot(TO_C - 1, MAXC, 1'b0);
        one_shot(TO_C, MAXC, 1'b1);

        // no echo: result TO_C cycles after trig falls
        exp_q.push_back({1'b1, 9'(MAXC)});
        pulse_start();
        wait_trig_fall();
        wait_drained();
        check("noecho_latency", vrise - last_fall, TO_C);
        wait_idle();

        // continuous mode, exact period, enable dropped mid-measurement
        n0 = rise_q.size();
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({1'b0, 9'd20});
            measure(20 * CPC, 7);
        end
        enable = 1'b0;
        wait_drained();
        repeat (PER_C) tick();
        check("cont_trig_count", rise_q.size() - n0, 3);
        check("cont_period_1", rise_q[n0 + 1] - rise_q[n0], PER_C);
        check("cont_period_2", rise_q[n0 + 2] - rise_q[n0 + 1], PER_C);
        check("cont_idle", busy, 0);

        // backpressure: result held, no relaunch until accepted
        dist_ready = 1'b0;
        n0 = rise_q.size();
        enable = 1'b1;
        exp_q.push_back({1'b0, 9'd10});
        measure(10 * CPC, 5);
        repeat (2 * PER_C + 1000) tick();
        check("bp_no_trig", rise_q.size() - n0, 1);
        check("bp_valid_held", dist_valid, 1);
        dist_ready = 1'b1;
        tick(); tick();
        a = acc_cyc;
        exp_q.push_back({1'b0, 9'd5});
        measure(5 * CPC, 5);
        enable = 1'b0;
        check("bp_relaunch", rise_q[n0 + 1] - a, 2);
        check("bp_spacing_ok", (rise_q[n0 + 1] - rise_q[n0]) >= PER_C, 1);
        wait_drained();
        wait_idle();

        // reset mid-measure with echo stuck high
        pulse_start();
        wait_trig_fall();
        repeat (5) tick();
        echo = 1'b1;
        repeat (100) tick();
        check("mid_state_measure", dbg_state, 3);
        rst = 1'b1;
        tick();
        check("mrst_trig", trig, 0);
        check("mrst_valid", dist_valid, 0);
        check("mrst_timeout", timeout, 0);
        check("mrst_dist", distance_cm, 0);
        check("mrst_busy", busy, 0);
        rst = 1'b0;
        repeat (10) tick();
        exp_q.push_back({1'b1, 9'(MAXC)});
        pulse_start();
        wait_drained();
        echo = 1'b0;
        wait_idle();

        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
